// File: rtl/spi_counter_core_if.sv
// Control/status bundle between the SPI register decoder (master) and the counter core (slave).
interface spi_counter_core_if #(
  parameter int unsigned WIDTH = 14
);
  logic             i_runstop;
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_dir;
  logic             i_sat;
  logic [WIDTH-1:0] counter;
  logic             o_tick;
  logic             o_tc;
  logic             o_ovf;

  modport master (
    output i_runstop, i_clear, i_load, i_load_val, i_dir, i_sat,
    input  counter, o_tick, o_tc, o_ovf
  );

  modport slave (
    input  i_runstop, i_clear, i_load, i_load_val, i_dir, i_sat,
    output counter, o_tick, o_tc, o_ovf
  );
endinterface

// File: rtl/spi_counter_core.sv
// Prescaled up/down counter with wrap/saturate, clamped parallel load and tc/ovf flags.
module spi_counter_core #(
  parameter int unsigned WIDTH     = 14,
  parameter int unsigned MAX_COUNT = 9999,
  parameter int unsigned TICK_DIV  = 100_000_000
) (
  input logic               clk,
  input logic               reset_n,
  spi_counter_core_if.slave bus
);
  localparam int unsigned      PreW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0]  PreLast = PreW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MAX_COUNT);

  if (MAX_COUNT < 1 || TICK_DIV < 1 || (64'(MAX_COUNT) >> WIDTH) != 64'd0) begin : g_param_check
    $error("spi_counter_core: MAX_COUNT must be 1..2^WIDTH-1 and TICK_DIV >= 1");
  end

  logic [PreW-1:0]  pre_q, pre_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  assign tick = bus.i_runstop && (pre_q == PreLast);

  always_comb begin
    pre_d     = pre_q;
    counter_d = counter_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    if (bus.i_clear) begin
      pre_d     = '0;
      counter_d = '0;
      ovf_d     = 1'b0;
    end else begin
      // Prescaler holds while stopped so a paused period resumes where it left off.
      if (bus.i_runstop) begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
      end
      if (bus.i_load) begin
        counter_d = (bus.i_load_val > MaxVal) ? MaxVal : bus.i_load_val;
      end else if (tick) begin
        if (bus.i_dir) begin
          if (counter_q < MaxVal) begin
            counter_d = counter_q + WIDTH'(1);
          end else begin
            counter_d = bus.i_sat ? MaxVal : '0;
            tc_d      = 1'b1;
            ovf_d     = 1'b1;
          end
        end else begin
          if (counter_q != '0) begin
            counter_d = counter_q - WIDTH'(1);
          end else begin
            counter_d = bus.i_sat ? '0 : MaxVal;
            tc_d      = 1'b1;
            ovf_d     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q     <= '0;
      counter_q <= '0;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      counter_q <= counter_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.counter = counter_q;
  assign bus.o_tick  = tick;
  assign bus.o_tc    = tc_q;
  assign bus.o_ovf   = ovf_q;
endmodule
